// File: rtl/lsu_misalign.sv
// Load/store front end for the data memory: aligned accesses pass straight through,
// misaligned loads become two word reads and misaligned stores become a run of byte writes.
module lsu_misalign #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  ld_valid,
    output logic [DATA_W-1:0]     ld_data
);

    localparam int         WORD_BYTES = DATA_W / 8;
    localparam int         CNT_W      = $clog2(WORD_BYTES);
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        LD_HI,
        ST_BYTE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     lo_buf_q, lo_buf_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [2:0]            funct3_q, funct3_d;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off == 2'b11;
            default: return off != 2'b00;
        endcase
    endfunction

    // Only byte and half codes carry an unsigned flag; every other code is a full word.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                     input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return f3[2] ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                              : {{(DATA_W-8){raw[7]}}, raw[7:0]};
            2'b01:   return f3[2] ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                              : {{(DATA_W-16){raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    logic                  req_mis;
    logic [DM_ADDRESS-1:0] req_addr_dm;
    logic [DM_ADDRESS-1:0] lo_addr;
    logic [DM_ADDRESS-1:0] hi_addr;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [2*DATA_W-1:0]   ld_pair;
    logic [DATA_W-1:0]     ld_raw;
    logic [7:0]            st_byte;
    logic                  st_last;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:DM_ADDRESS];
    assign req_addr_dm    = req_addr[DM_ADDRESS-1:0];
    assign req_mis        = req_valid & is_misaligned(req_funct3, req_addr[1:0]);
    assign lo_addr        = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign hi_addr        = lo_addr + DM_ADDRESS'(4);
    assign st_addr        = addr_q + DM_ADDRESS'(32'(cnt_q) + 1);
    assign ld_pair        = {mem_rdata, lo_buf_q};
    assign ld_raw         = DATA_W'(ld_pair >> (8 * int'(addr_q[1:0])));
    assign st_byte        = 8'(wdata_q >> (8 * (int'(cnt_q) + 1)));
    assign st_last        = (funct3_q[1:0] == 2'b01) ? (cnt_q == '0)
                                                     : (cnt_q == CNT_W'(WORD_BYTES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lo_buf_q <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            funct3_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lo_buf_q <= lo_buf_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lo_buf_d   = lo_buf_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        funct3_d   = funct3_q;
        mem_read   = req_read;
        mem_write  = req_write & ~req_read;
        mem_addr   = req_addr_dm;
        mem_wdata  = req_wdata;
        mem_funct3 = req_funct3;
        stall      = 1'b0;
        ld_valid   = req_valid & req_read;
        ld_data    = mem_rdata;

        case (state_q)
            IDLE: begin
                if (req_mis && req_read) begin
                    mem_read   = 1'b1;
                    mem_write  = 1'b0;
                    mem_addr   = {req_addr_dm[DM_ADDRESS-1:2], 2'b00};
                    mem_funct3 = F3_LW;
                    stall      = 1'b1;
                    ld_valid   = 1'b0;
                    lo_buf_d   = mem_rdata;
                    addr_d     = req_addr_dm;
                    funct3_d   = req_funct3;
                    state_d    = LD_HI;
                end else if (req_mis && req_write) begin
                    mem_read   = 1'b0;
                    mem_write  = 1'b1;
                    mem_wdata  = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
                    mem_funct3 = F3_SB;
                    stall      = 1'b1;
                    ld_valid   = 1'b0;
                    addr_d     = req_addr_dm;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    cnt_d      = '0;
                    state_d    = ST_BYTE;
                end
            end
            LD_HI: begin
                mem_read   = 1'b1;
                mem_write  = 1'b0;
                mem_addr   = hi_addr;
                mem_wdata  = '0;
                mem_funct3 = F3_LW;
                ld_valid   = 1'b1;
                ld_data    = extend_load(ld_raw, funct3_q);
                state_d    = IDLE;
            end
            ST_BYTE: begin
                mem_read   = 1'b0;
                mem_write  = 1'b1;
                mem_addr   = st_addr;
                mem_wdata  = {{(DATA_W-8){1'b0}}, st_byte};
                mem_funct3 = F3_SB;
                ld_valid   = 1'b0;
                cnt_d      = cnt_q + CNT_W'(1);
                stall      = ~st_last;
                if (st_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_misalign.sv
// Self-checking bench for lsu_misalign: a byte-array data memory answers the DUT and a
// byte-level reference memory predicts every load result and the memory image after stores.
module tb_lsu_misalign;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        stall, ld_valid;
    logic [31:0] ld_data;

    logic [7:0]  dmem    [512];
    logic [7:0]  ref_mem [512];
    int          tests_run = 0;
    int          fail_count = 0;

    lsu_misalign #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
        .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] extend_val(input logic [31:0] v, input logic [2:0] f3);
        int n;
        logic [31:0] res;
        n = size_of(f3);
        if (n == 4) return v;
        res = v & ((32'd1 << (8 * n)) - 32'd1);
        if (!f3[2] && res[8*n-1]) res = res | (32'hFFFF_FFFF << (8 * n));
        return res;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size_of(f3); i++)
            v = v | (32'(ref_mem[(a + i) % 512]) << (8 * i));
        return extend_val(v, f3);
    endfunction

    function automatic logic [31:0] dmem_read(input int a, input logic [2:0] f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size_of(f3); i++)
            v = v | (32'(dmem[(a + i) % 512]) << (8 * i));
        return extend_val(v, f3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [2:0] f3);
        req_valid  = v;
        req_read   = rd;
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
    endtask

    task automatic settle();
        #1;
        mem_rdata = mem_read ? dmem_read(int'(mem_addr), mem_funct3) : 32'hDEAD_BEEF;
    endtask

    // Commit whatever write the DUT presents at the coming rising edge into the memory.
    task automatic endCycle();
        logic        w_en;
        logic [8:0]  w_addr;
        logic [2:0]  w_f3;
        logic [31:0] w_data;
        w_en   = mem_write;
        w_addr = mem_addr;
        w_f3   = mem_funct3;
        w_data = mem_wdata;
        @(posedge clk);
        if (w_en)
            for (int i = 0; i < size_of(w_f3); i++)
                dmem[(int'(w_addr) + i) % 512] = w_data[8*i +: 8];
        #1;
    endtask

    task automatic doTxn(input bit is_store, input logic [8:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] got);
        int          n, sz, ai;
        bit          mis;
        logic [31:0] r, exp_addr, exp_f3, exp_wd, sh;
        sz  = size_of(f3);
        ai  = int'(a);
        mis = (sz == 2 && a[1:0] == 2'b11) || (sz == 4 && a[1:0] != 2'b00);
        n   = !mis ? 1 : (is_store ? sz : 2);
        got = 32'hX;
        for (int k = 0; k < n; k++) begin
            r = $urandom();
            if (k == 0)
                applyStimulus(1'b1, !is_store, is_store, {r[31:9], a}, wd, f3);
            else
                applyStimulus(r[0], r[1], r[2], $urandom(), $urandom(), r[5:3]);
            settle();
            @(negedge clk);
            if (!mis) begin
                exp_addr = 32'(a);
                exp_f3   = 32'(f3);
                exp_wd   = wd;
            end else if (!is_store) begin
                exp_addr = 32'(((ai & ~3) + 4 * k) % 512);
                exp_f3   = 32'd2;
                exp_wd   = 32'd0;
            end else begin
                sh       = wd >> (8 * k);
                exp_addr = 32'((ai + k) % 512);
                exp_f3   = 32'd0;
                exp_wd   = {24'd0, sh[7:0]};
            end
            checkOutput("stall", 32'(stall), 32'(k < n - 1));
            checkOutput("ld_valid", 32'(ld_valid), 32'(!is_store && k == n - 1));
            checkOutput("mem_read", 32'(mem_read), 32'(!is_store));
            checkOutput("mem_write", 32'(mem_write), 32'(is_store));
            checkOutput("mem_addr", 32'(mem_addr), exp_addr);
            checkOutput("mem_funct3", 32'(mem_funct3), exp_f3);
            if (is_store) checkOutput("mem_wdata", mem_wdata, exp_wd);
            if (!is_store && k == n - 1) begin
                got = ld_data;
                checkOutput("ld_data", ld_data, ref_load(ai, f3));
            end
            endCycle();
        end
        if (is_store)
            for (int i = 0; i < sz; i++)
                ref_mem[(ai + i) % 512] = wd[8*i +: 8];
    endtask

    initial begin
        logic [31:0] got, r;
        int          bad;

        for (int i = 0; i < 512; i++) begin
            r = $urandom();
            ref_mem[i] = r[7:0];
        end
        {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]}   = 32'h4433_2211;
        {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}   = 32'h8877_6655;
        {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]} = 32'h0000_00AA;
        for (int i = 0; i < 512; i++) dmem[i] = ref_mem[i];

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        settle();
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset ld_valid", 32'(ld_valid), 32'd0);
        checkOutput("reset mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset mem_write", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        doTxn(1'b0, 9'h000, 3'b010, 32'd0, got);
        checkOutput("lw aligned", got, 32'h4433_2211);
        doTxn(1'b0, 9'h001, 3'b010, 32'd0, got);
        checkOutput("lw mis", got, 32'h5544_3322);
        doTxn(1'b0, 9'h007, 3'b001, 32'd0, got);
        checkOutput("lh mis", got, 32'hFFFF_AA88);
        doTxn(1'b0, 9'h007, 3'b101, 32'd0, got);
        checkOutput("lhu mis", got, 32'h0000_AA88);
        doTxn(1'b0, 9'h002, 3'b000, 32'd0, got);
        checkOutput("lb 002", got, 32'h0000_0033);
        doTxn(1'b0, 9'h007, 3'b000, 32'd0, got);
        checkOutput("lb 007", got, 32'hFFFF_FF88);

        // Reset lands in the second half of a misaligned load and must kill it at once.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'd0, 3'b010);
        settle();
        @(negedge clk);
        checkOutput("abort stall c1", 32'(stall), 32'd1);
        checkOutput("abort addr c1", 32'(mem_addr), 32'h000);
        endCycle();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        settle();
        checkOutput("abort stall", 32'(stall), 32'd0);
        checkOutput("abort ld_valid", 32'(ld_valid), 32'd0);
        checkOutput("abort mem_read", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        doTxn(1'b0, 9'h000, 3'b010, 32'd0, got);
        checkOutput("lw after abort", got, 32'h4433_2211);

        doTxn(1'b1, 9'h1FF, 3'b010, 32'hDDCC_BBAA, got);
        checkOutput("sw wrap image", {dmem[2], dmem[1], dmem[0], dmem[511]}, 32'hDDCC_BBAA);
        doTxn(1'b0, 9'h1FF, 3'b010, 32'd0, got);
        checkOutput("lw wrap", got, 32'hDDCC_BBAA);

        for (int t = 0; t < 120; t++) begin
            r = $urandom();
            doTxn(r[0], 9'($urandom_range(0, 511)), r[3:1], $urandom(), got);
        end

        bad = 0;
        for (int i = 0; i < 512; i++)
            if (dmem[i] !== ref_mem[i]) bad++;
        checkOutput("final memory image", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/lsu_misalign.md
LSU_MISALIGN -- requirements
Module: lsu_misalign

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, the data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-005 SHALL have req_valid, input, 1: EX/MEM holds a memory instruction.
REQ-006 SHALL have req_read and req_write, inputs, 1 each: load or store; both high is treated as a load.
REQ-007 SHALL have req_addr, input, 32: byte address; only bits [DM_ADDRESS-1:0] are used.
REQ-008 SHALL have req_wdata, input, DATA_W: store data, and req_funct3, input, 3: access type.
REQ-009 SHALL have mem_read and mem_write, outputs, 1 each, driving the data memory.
REQ-010 SHALL have mem_addr (DM_ADDRESS), mem_wdata (DATA_W) and mem_funct3 (3), outputs, to the data memory.
REQ-011 SHALL have mem_rdata, input, DATA_W: data-memory read data, valid combinationally in the same cycle.
REQ-012 SHALL have stall, output, 1: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-013 SHALL have ld_valid, output, 1, and ld_data, output, DATA_W: the final, extended load result.

Function
REQ-014 SHALL derive size from funct3[1:0]: 00 byte, 01 half, others word; unsigned when funct3[2]=1; illegal codes are signed word.
REQ-015 SHALL classify an access as misaligned when it is a half with addr[1:0]=11 or a word with addr[1:0]!=00; bytes are never misaligned.
REQ-016 SHALL implement FSM states IDLE, LD_HI and ST_BYTE.
REQ-017 IDLE, aligned or req_valid=0: pass req_read/req_write/addr/wdata/funct3 to the mem_* outputs combinationally; stall=0; ld_valid=req_valid&req_read; ld_data=mem_rdata.
REQ-018 IDLE, misaligned load: issue LW at {addr[8:2],00}; stall=1; ld_valid=0; capture mem_rdata into lo_buf, latch addr/funct3, then go to LD_HI.
REQ-019 LD_HI: issue LW at lo address+4 mod 2^DM_ADDRESS; stall=0; ld_valid=1; go to IDLE.
REQ-020 LD_HI ld_data: take the DATA_W bits of {mem_rdata,lo_buf} starting at bit 8*addr[1:0], truncate to the access size, then sign- or zero-extend per funct3.
REQ-021 IDLE, misaligned store: latch addr/wdata; set cnt=0; issue SB at addr with mem_wdata={24'b0,wdata[7:0]}; stall=1; go to ST_BYTE.
REQ-022 ST_BYTE: issue SB at addr+cnt+1 mod 2^DM_ADDRESS with byte wdata[8*(cnt+1)+:8]; increment cnt.
REQ-023 ST_BYTE stall: stays 1 until the last byte (cnt+1 = size-1); on the last byte stall=0 and the FSM returns to IDLE; half stores total 2 cycles, word stores 4.
REQ-024 SHALL hold mem_read=0 during store sequences, hold mem_write=0 during load sequences, and keep ld_valid=0 for stores.
REQ-025 Request inputs SHALL be ignored outside IDLE; the latched copies are used.
REQ-026 Address arithmetic SHALL wrap modulo 2^DM_ADDRESS; 0x1FF+1 = 0x000.

Reset
REQ-027 While rst_n=0: state=IDLE, cnt=0, lo_buf=0, latched registers=0; outputs then follow REQ-017, so with req_valid=0, stall=0 and ld_valid=0.
REQ-028 Reset asserted mid-sequence SHALL abort it immediately; no further memory access is issued, the partial store is not rolled back, and no load result is produced.

Verification
(Memory preset: word 0x000 = 0x44332211, word 0x004 = 0x88776655.)
REQ-029 LW addr 0x000 -> one cycle; stall=0; ld_valid=1; ld_data=0x44332211.
REQ-030 LW addr 0x001 -> cycle 1: stall=1, mem_addr=0x000; cycle 2: stall=0, mem_addr=0x004, ld_data=0x55443322.
REQ-031 LH addr 0x007 with word 0x008=0x000000AA -> ld_data=0xFFFFAA88; LHU at the same address -> 0x0000AA88.
REQ-032 SW addr 0x1FF, wdata 0xDDCCBBAA -> four SB cycles at 0x1FF, 0x000, 0x001, 0x002 with bytes AA, BB, CC, DD; stall=1,1,1,0.
REQ-033 LB addr 0x002 -> one cycle; ld_data=0x00000033. LB addr 0x007 -> one cycle; ld_data=0xFFFFFF88.
REQ-034 rst_n low during the LD_HI cycle of REQ-030 -> state=IDLE, ld_valid=0, stall=0 immediately; the next aligned LW completes normally.
